// File: rtl/perf_monitor.sv
// perf_monitor -- run-length performance counter block.
//
// Counts cycles, retired instructions and (optionally) stalled non-retiring
// cycles between leaving IDLE and reaching HALTED. HALTED is entered when the
// halt encoding retires or when IDLE_LIMIT consecutive RUN cycles pass with
// no retire (the idle watchdog).
//
// Optional feature macro: PERF_STALL_CNT_EN
//   defined   -> stall_cycles counts stalled, non-retiring RUN cycles
//   undefined -> no stall counter; stall_cycles is tied to zero
//
// Ports:
//   clk           in   sole clock, rising edge
//   reset         in   asynchronous active-high reset
//   retire_valid  in   one instruction retires this cycle
//   retire_instr  in   [31:0] encoding of the retiring instruction
//   stall         in   pipeline stalled this cycle
//   clear         in   synchronous restart of measurement (beats everything)
//   cycles        out  [CNT_W-1:0] cycles spent in RUN
//   instret       out  [CNT_W-1:0] instructions retired in RUN
//   stall_cycles  out  [CNT_W-1:0] stalled non-retiring RUN cycles
//   running       out  high while in RUN
//   halted        out  high while in HALTED
//   timeout       out  HALTED was entered through the idle watchdog
//   done          out  one-cycle pulse after the edge that enters HALTED
`timescale 1ns/1ps

module perf_monitor #(
  parameter int          CNT_W      = 32,
  parameter logic [31:0] HALT_INSTR = 32'h00100073,
  parameter int          IDLE_LIMIT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             retire_valid,
  input  logic [31:0]      retire_instr,
  input  logic             stall,
  input  logic             clear,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] instret,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             running,
  output logic             halted,
  output logic             timeout,
  output logic             done
);

  // Wide enough to hold IDLE_LIMIT itself, so the compare below is exact.
  localparam int IDLE_W = $clog2(IDLE_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cycles;
  logic [CNT_W-1:0]  r_instret;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [IDLE_W-1:0] w_idle_inc;
  logic              r_timeout;
  logic              r_done;
  logic              w_halt_retire;
  logic              w_idle_hit;

  // Saturating increment: all-ones is sticky rather than wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_halt_retire = retire_valid && (retire_instr == HALT_INSTR);
  assign w_idle_inc    = r_idle_cnt + IDLE_W'(1);
  // The watchdog fires on the non-retiring edge that would bring the idle
  // count up to the limit, so the halt lands after exactly IDLE_LIMIT edges.
  assign w_idle_hit    = !retire_valid && (w_idle_inc == IDLE_W'(IDLE_LIMIT));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   w_state_next = S_RUN;
        S_RUN:    if (w_halt_retire || w_idle_hit) w_state_next = S_HALTED;
        S_HALTED: w_state_next = S_HALTED;
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs (decoded from the state register) ----------------
  always_comb begin
    running = 1'b0;
    halted  = 1'b0;
    case (r_state)
      S_RUN:    running = 1'b1;
      S_HALTED: halted  = 1'b1;
      default:  ;
    endcase
  end

  // ---------------- counters and status flags ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycles   <= '0;
      r_instret  <= '0;
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
      r_done     <= 1'b0;
    end else if (clear) begin
      r_cycles   <= '0;
      r_instret  <= '0;
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == S_RUN) && (w_state_next == S_HALTED);
      if (r_state == S_RUN) begin
        r_cycles <= sat_inc(r_cycles);
        if (retire_valid) begin
          r_instret  <= sat_inc(r_instret);
          r_idle_cnt <= '0;
        end else begin
          r_idle_cnt <= w_idle_inc;
        end
        // A halt retire on the same edge always wins over the watchdog.
        if (w_idle_hit && !w_halt_retire) begin
          r_timeout <= 1'b1;
        end
      end
    end
  end

`ifdef PERF_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles;

  // Only stalls that also fail to retire are charged as lost cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (clear) begin
      r_stall_cycles <= '0;
    end else if ((r_state == S_RUN) && stall && !retire_valid) begin
      r_stall_cycles <= sat_inc(r_stall_cycles);
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  logic w_unused_stall;

  assign w_unused_stall = stall;
  assign stall_cycles   = '0;
`endif

  assign cycles  = r_cycles;
  assign instret = r_instret;
  assign timeout = r_timeout;
  assign done    = r_done;

endmodule

// File: tb/tb_perf_monitor.sv
`timescale 1ns/1ps

module tb_perf_monitor;

  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam logic [31:0] ADDI   = 32'h00100093;
`ifdef PERF_STALL_CNT_EN
  localparam logic [31:0] STALL_EXP = 32'd3;
`else
  localparam logic [31:0] STALL_EXP = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        retire_valid, stall, clear;
  logic [31:0] retire_instr;
  logic [31:0] cycles, instret, stall_cycles;
  logic        running, halted, timeout, done;

  // Narrow instance for saturation checks
  logic        rv4, stall4, clear4;
  logic [31:0] instr4;
  logic [3:0]  cycles4, instret4, stall_cycles4;
  logic        running4, halted4, timeout4, done4;

  always #5 clk = ~clk;

  perf_monitor dut (
    .clk(clk), .reset(reset), .retire_valid(retire_valid),
    .retire_instr(retire_instr), .stall(stall), .clear(clear),
    .cycles(cycles), .instret(instret), .stall_cycles(stall_cycles),
    .running(running), .halted(halted), .timeout(timeout), .done(done)
  );

  perf_monitor #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .retire_valid(rv4),
    .retire_instr(instr4), .stall(stall4), .clear(clear4),
    .cycles(cycles4), .instret(instret4), .stall_cycles(stall_cycles4),
    .running(running4), .halted(halted4), .timeout(timeout4), .done(done4)
  );

  typedef struct {
    logic [31:0] cyc;
    logic [31:0] ins;
    logic [31:0] stl;
    logic        to;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb4_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rv, input logic st, input logic [31:0] ins);
    retire_valid = rv;
    stall        = st;
    retire_instr = ins;
    tick();
  endtask

  // Monitor: every done pulse pops one expected result and compares.
  always @(negedge clk) begin : mon_main
    exp_t e;
    if (!reset && done) begin
      chk("done_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk({e.name, ".cycles"}, cycles, e.cyc);
        chk({e.name, ".instret"}, instret, e.ins);
        chk({e.name, ".stall_cycles"}, stall_cycles, e.stl);
        chk({e.name, ".timeout"}, 32'(timeout), 32'(e.to));
        chk({e.name, ".halted"}, 32'(halted), 32'd1);
        $display("done seen: %s cycles=%0d instret=%0d stall=%0d timeout=%0b",
                 e.name, cycles, instret, stall_cycles, timeout);
      end
    end
  end

  always @(negedge clk) begin : mon_narrow
    exp_t e;
    if (!reset && done4) begin
      chk("done4_expected", 32'(sb4_q.size() != 0), 32'd1);
      if (sb4_q.size() != 0) begin
        e = sb4_q.pop_front();
        chk({e.name, ".cycles"}, {28'd0, cycles4}, e.cyc);
        chk({e.name, ".instret"}, {28'd0, instret4}, e.ins);
        chk({e.name, ".timeout"}, 32'(timeout4), 32'(e.to));
        $display("done4 seen: %s cycles=%0d instret=%0d", e.name, cycles4, instret4);
      end
    end
  end

  initial begin
    reset = 1'b1; clear = 1'b0; retire_valid = 1'b0; stall = 1'b0; retire_instr = 32'd0;
    clear4 = 1'b1; rv4 = 1'b0; stall4 = 1'b0; instr4 = 32'd0;

    // Reset state
    #10;
    chk("rst.cycles", cycles, 32'd0);
    chk("rst.instret", instret, 32'd0);
    chk("rst.flags", {28'd0, running, halted, timeout, done}, 32'd0);
    #10 reset = 1'b0;

    // IDLE -> RUN edge counts nothing
    tick();
    chk("enter_run.running", 32'(running), 32'd1);
    chk("enter_run.cycles", cycles, 32'd0);

    // 8 ADDI then EBREAK
    sb_q.push_back('{cyc: 32'd9, ins: 32'd9, stl: 32'd0, to: 1'b0, name: "ebreak_run"});
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, ADDI);
    drive(1'b1, 1'b0, EBREAK);
    chk("ebreak_run.halted_now", 32'(halted), 32'd1);
    // Activity in HALTED is ignored
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, ADDI);
    drive(1'b0, 1'b0, ADDI);
    chk("halted_hold.cycles", cycles, 32'd9);
    chk("halted_hold.instret", instret, 32'd9);
    chk("halted_hold.halted", 32'(halted), 32'd1);

    // Stall-only cycles interleaved with retires
    clear = 1'b1; tick();
    chk("clear.cycles", cycles, 32'd0);
    chk("clear.state", {30'd0, running, halted}, 32'd0);
    clear = 1'b0; tick();
    sb_q.push_back('{cyc: 32'd7, ins: 32'd4, stl: STALL_EXP, to: 1'b0, name: "stall_mix"});
    drive(1'b1, 1'b0, ADDI);
    drive(1'b0, 1'b1, ADDI);
    drive(1'b1, 1'b0, ADDI);
    drive(1'b0, 1'b1, ADDI);
    drive(1'b1, 1'b1, ADDI);
    drive(1'b0, 1'b1, ADDI);
    drive(1'b1, 1'b0, EBREAK);
    drive(1'b0, 1'b0, ADDI);

    // Idle watchdog timeout
    clear = 1'b1; tick(); clear = 1'b0; tick();
    sb_q.push_back('{cyc: 32'd64, ins: 32'd0, stl: 32'd0, to: 1'b1, name: "watchdog"});
    for (int i = 0; i < 63; i++) tick();
    chk("watchdog.still_running", 32'(running), 32'd1);
    tick();
    chk("watchdog.halted", 32'(halted), 32'd1);
    chk("watchdog.timeout", 32'(timeout), 32'd1);
    tick(); tick();

    // EBREAK on the edge the watchdog would otherwise fire
    clear = 1'b1; tick(); clear = 1'b0; tick();
    sb_q.push_back('{cyc: 32'd64, ins: 32'd1, stl: 32'd0, to: 1'b0, name: "halt_vs_idle"});
    for (int i = 0; i < 63; i++) tick();
    drive(1'b1, 1'b0, EBREAK);
    chk("halt_vs_idle.timeout", 32'(timeout), 32'd0);
    drive(1'b0, 1'b0, ADDI);

    // clear in HALTED together with EBREAK retire
    clear = 1'b1;
    drive(1'b1, 1'b0, EBREAK);
    chk("clr_halted.counts", cycles | instret, 32'd0);
    chk("clr_halted.flags", {28'd0, running, halted, timeout, done}, 32'd0);
    clear = 1'b0;
    drive(1'b0, 1'b0, ADDI);
    chk("clr_halted.next_run", 32'(running), 32'd1);
    drive(1'b1, 1'b0, ADDI);
    drive(1'b1, 1'b0, ADDI);
    clear = 1'b1;
    drive(1'b1, 1'b0, EBREAK);
    chk("clr_ebreak.counts", cycles | instret, 32'd0);
    chk("clr_ebreak.flags", {28'd0, running, halted, timeout, done}, 32'd0);
    clear = 1'b0;
    drive(1'b0, 1'b0, ADDI);

    // Asynchronous reset mid-RUN
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, ADDI);
    chk("pre_reset.cycles", cycles, 32'd5);
    retire_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("async_rst.counts", cycles | instret | stall_cycles, 32'd0);
    chk("async_rst.flags", {28'd0, running, halted, timeout, done}, 32'd0);
    #2 reset = 1'b0;
    tick();
    chk("post_reset.running", 32'(running), 32'd1);
    chk("post_reset.cycles", cycles, 32'd0);

    // Saturation on the 4-bit instance; park the main instance
    clear = 1'b1;
    clear4 = 1'b0;
    tick();
    sb4_q.push_back('{cyc: 32'hF, ins: 32'hF, stl: 32'd0, to: 1'b0, name: "sat4"});
    rv4 = 1'b1; instr4 = ADDI;
    for (int i = 0; i < 20; i++) tick();
    chk("sat4.cycles", {28'd0, cycles4}, 32'hF);
    chk("sat4.instret", {28'd0, instret4}, 32'hF);
    instr4 = EBREAK; tick();
    rv4 = 1'b0; tick(); tick();

    chk("sb_main_drained", 32'(sb_q.size()), 32'd0);
    chk("sb_narrow_drained", 32'(sb4_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 32, counter width in bits.
REQ-002 SHALL have parameter HALT_INSTR, default 32'h00100073 (EBREAK), retired encoding that ends the run.
REQ-003 SHALL have parameter IDLE_LIMIT, default 64, count of consecutive non-retiring RUN cycles that forces a timeout halt.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port retire_valid, input, 1, one instruction retires this cycle.
REQ-007 SHALL have port retire_instr, input, 32, encoding of the retiring instruction; qualified by retire_valid.
REQ-008 SHALL have port stall, input, 1, pipeline stalled this cycle.
REQ-009 SHALL have port clear, input, 1, synchronous restart of measurement.
REQ-010 SHALL have port cycles, output, CNT_W, cycles spent in RUN.
REQ-011 SHALL have port instret, output, CNT_W, instructions retired in RUN.
REQ-012 SHALL have port stall_cycles, output, CNT_W, stalled non-retiring RUN cycles (see Configuration).
REQ-013 SHALL have port running, output, 1, high while in RUN.
REQ-014 SHALL have port halted, output, 1, high while in HALTED.
REQ-015 SHALL have port timeout, output, 1, set when HALTED was entered via the idle watchdog.
REQ-016 SHALL have port done, output, 1, single-cycle pulse on entry to HALTED.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, HALTED.
REQ-018 IDLE SHALL go to RUN on the first rising edge with reset low and clear low; that edge SHALL NOT increment any counter.
REQ-019 In RUN each rising edge SHALL increment cycles by 1.
REQ-020 In RUN, edge with retire_valid=1 SHALL increment instret by 1.
REQ-021 In RUN, edge with stall=1 and retire_valid=0 SHALL increment stall_cycles by 1; stall with retire_valid=1 SHALL NOT count.
REQ-022 In RUN, retire_valid=1 with retire_instr==HALT_INSTR SHALL go to HALTED; that edge SHALL still increment cycles and instret.
REQ-023 SHALL keep an idle counter cleared on any retire, incremented on each non-retiring RUN edge; reaching IDLE_LIMIT SHALL go to HALTED with timeout=1.
REQ-024 Halt retire and idle-limit on the same edge: halt retire wins; timeout=0.
REQ-025 Each counter SHALL saturate at all-ones; no wrap to zero.
REQ-026 In HALTED all counters SHALL hold; retire_valid/stall ignored; only clear or reset leaves HALTED.
REQ-027 done SHALL be high exactly the one cycle after the edge entering HALTED.
REQ-028 retire_valid/stall in IDLE SHALL be ignored.
REQ-029 clear=1 on an edge SHALL, from any state, zero all counters, idle counter, timeout, done and go to IDLE; clear overrides every simultaneous event.
REQ-030 Outputs SHALL be registered; counter values reflect edges up to and including the previous one.

Reset
REQ-031 reset=1 SHALL immediately, without clk, force IDLE, cycles=0, instret=0, stall_cycles=0, running=0, halted=0, timeout=0, done=0, idle counter=0.
REQ-032 reset asserted mid-RUN or in HALTED SHALL discard all counts; release resumes per REQ-018.

Configuration
REQ-033 Macro PERF_STALL_CNT_EN defined: stall_cycles counts per REQ-021.
REQ-034 Macro PERF_STALL_CNT_EN undefined: no stall counter logic; stall_cycles tied to 0; stall input unused; all other behaviour unchanged.

Verification
REQ-035 Reset 20 ns, 8 retires of ADDI then EBREAK one per cycle -> instret=9, cycles=9, done pulse once, halted=1, timeout=0.
REQ-036 Retires with 3 stall-only cycles interleaved, then EBREAK -> stall_cycles=3 (0 without PERF_STALL_CNT_EN), cycles=instret+3.
REQ-037 IDLE_LIMIT=64, no retires after reset release -> HALTED after 64 RUN edges, cycles=64, instret=0, timeout=1, done pulse.
REQ-038 CNT_W=4, 20 retires no halt -> instret stays 4'hF, cycles stays 4'hF.
REQ-039 clear asserted in HALTED and on the edge of an EBREAK retire -> counters 0, IDLE, no done; next edge RUN.
REQ-040 reset asserted between edges mid-RUN with cycles=5 -> all outputs 0 before next clk edge.
